// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 core: opcodes, FSM states, instruction fields.
package cvp14_pkg;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SLH  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_BEQZ = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 9;
  localparam int RS_LSB = 6;
  localparam int RT_LSB = 3;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_LDWB, S_HALT} state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [5:0]  imm6;
    logic [7:0]  imm8;
    logic [8:0]  imm9;
    logic [11:0] imm12;
  } instr_t;

  function automatic instr_t decode(input logic [15:0] ir);
    instr_t f;
    f.op    = ir[OP_LSB +: 4];
    f.rd    = ir[RD_LSB +: 3];
    f.rs    = ir[RS_LSB +: 3];
    f.rt    = ir[RT_LSB +: 3];
    f.imm6  = ir[5:0];
    f.imm8  = ir[7:0];
    f.imm9  = ir[8:0];
    f.imm12 = ir[11:0];
    return f;
  endfunction
endpackage

// File: rtl/cvp14_alu.sv
// CVP14 ALU: ADD/SUB/AND/XOR with signed overflow.
// CVP14_SAT_ARITH_EN: saturate ADD/SUB results on overflow instead of wrapping.
module cvp14_alu
  import cvp14_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o,
  output logic        ovf_o
);
  logic        sub;
  logic [15:0] b_eff;
  logic [15:0] sum;

  always_comb begin
    sub   = (op_i == OP_SUB);
    b_eff = sub ? ~b_i : b_i;
    sum   = a_i + b_eff + {15'd0, sub};
    y_o   = 16'h0000;
    ovf_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        // SUB is a + ~b + 1, so one sign test covers both operations
        ovf_o = (a_i[15] == b_eff[15]) && (sum[15] != a_i[15]);
`ifdef CVP14_SAT_ARITH_EN
        y_o = ovf_o ? (a_i[15] ? 16'h8000 : 16'h7FFF) : sum;
`else
        y_o = sum;
`endif
      end
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = 16'h0000;
    endcase
  end
endmodule

// File: rtl/cvp14_core.sv
// CVP14 multi-cycle core: FETCH/DECODE/EXEC/LDWB/HALT over a 1-cycle-latency memory bus.
// CVP14_SAT_ARITH_EN (in cvp14_alu) selects saturating ADD/SUB.
module cvp14_core
  import cvp14_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] DataOut,
  output logic        V
);
  state_e            state_q;
  logic [15:0]       pc_q;
  logic [15:0]       ir_q;
  logic              v_q;
  logic [7:0][15:0]  rf_q;

  instr_t      f;
  logic [15:0] rs_val, rt_val, rd_val, ea, br_tgt, alu_y;
  logic        alu_ovf;

  assign f      = decode(ir_q);
  assign rs_val = rf_q[f.rs];
  assign rt_val = rf_q[f.rt];
  assign rd_val = rf_q[f.rd];
  assign ea     = rs_val + {10'd0, f.imm6};
  // pc_q already points past the branch by the time EXEC runs
  assign br_tgt = pc_q + {{7{f.imm9[8]}}, f.imm9};

  cvp14_alu u_alu (
    .op_i  (f.op),
    .a_i   (rs_val),
    .b_i   (rt_val),
    .y_o   (alu_y),
    .ovf_o (alu_ovf)
  );

  always_comb begin
    Addr    = pc_q;
    RD      = 1'b0;
    WR      = 1'b0;
    DataOut = 16'h0000;
    case (state_q)
      S_FETCH: RD = 1'b1;
      S_EXEC: begin
        if (f.op == OP_LD) begin
          Addr = ea;
          RD   = 1'b1;
        end else if (f.op == OP_ST) begin
          Addr    = ea;
          WR      = 1'b1;
          DataOut = rd_val;
        end
      end
      default: ;
    endcase
    // Keep the bus quiet while reset is held, whatever state we were in
    if (Reset) begin
      RD      = 1'b0;
      WR      = 1'b0;
      DataOut = 16'h0000;
    end
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      v_q     <= 1'b0;
      rf_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= DataIn;
          pc_q    <= pc_q + 16'd1;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          case (f.op)
            OP_ADD, OP_SUB: begin
              rf_q[f.rd] <= alu_y;
              v_q        <= alu_ovf;
            end
            OP_AND, OP_XOR: rf_q[f.rd] <= alu_y;
            OP_SLL:  rf_q[f.rd][7:0]  <= f.imm8;
            OP_SLH:  rf_q[f.rd][15:8] <= f.imm8;
            OP_LD:   state_q <= S_LDWB;
            OP_J:    pc_q <= {pc_q[15:12], f.imm12};
            OP_BEQZ: if (rd_val == 16'h0000) pc_q <= br_tgt;
            OP_HALT: state_q <= S_HALT;
            default: ;
          endcase
        end
        S_LDWB: begin
          rf_q[f.rd] <= DataIn;
          state_q    <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign V = v_q;
endmodule

// File: tb/tb_cvp14_core.sv
// Scoreboard bench for cvp14_core: an ISA-level model predicts memory writes, V and cycle counts.
module tb_cvp14_core;
  import cvp14_pkg::*;

  logic        Clk1 = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] DataIn, Addr, DataOut;
  logic        RD, WR, V;

  always #5 Clk1 = ~Clk1;

  cvp14_core dut (
    .Clk1(Clk1), .Reset(Reset), .DataIn(DataIn), .Addr(Addr),
    .RD(RD), .WR(WR), .DataOut(DataOut), .V(V)
  );

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  always @(posedge Clk1) begin
    if (WR) mem[Addr] = DataOut;
    if (RD) DataIn <= mem[Addr];
  end

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  logic [15:0] tr_addr [64];
  logic        tr_rd   [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every DUT write is matched against the next predicted write
  always @(negedge Clk1) begin
    wr_t e;
    if (!Reset && WR) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wr_unexpected: got addr %h data %h, expected no write", Addr, DataOut);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {16'h0, Addr}, {16'h0, e.a});
        chk("wr_data", {16'h0, DataOut}, {16'h0, e.d});
      end
    end
  end

  function automatic logic [15:0] iR(input logic [3:0] op, input int d, input int s, input int t);
    return {op, 3'(d), 3'(s), 3'(t), 3'd0};
  endfunction
  function automatic logic [15:0] iI8(input logic [3:0] op, input int d, input logic [7:0] imm);
    return {op, 3'(d), 1'b0, imm};
  endfunction
  function automatic logic [15:0] iM(input logic [3:0] op, input int d, input int s, input logic [5:0] imm);
    return {op, 3'(d), 3'(s), imm};
  endfunction
  localparam logic [15:0] HALT_W = 16'hF000;

  // ISA interpreter: runs from reset state on ref_mem, pushes expected writes,
  // returns the cycle index (from reset release) at which the third idle cycle of HALT is seen
  task automatic ref_run(output int cyc, output logic vout, output bit ok);
    logic [15:0] r [8];
    logic [15:0] pc, ir, a, b, ea;
    int          sa, sb, s;
    logic        v;
    int          rd, rs, rt;
    for (int i = 0; i < 8; i++) r[i] = 16'h0;
    pc = RESET_PC_DEF; v = 1'b0; cyc = 0; ok = 1'b0; vout = 1'b0;
    for (int step = 0; step < 2000; step++) begin
      ir = ref_mem[pc];
      pc = pc + 16'd1;
      rd = int'(ir[11:9]); rs = int'(ir[8:6]); rt = int'(ir[5:3]);
      a = r[rs]; b = r[rt];
      sa = int'($signed(a)); sb = int'($signed(b));
      ea = a + {10'd0, ir[5:0]};
      case (ir[15:12])
        OP_ADD, OP_SUB: begin
          s = (ir[15:12] == OP_ADD) ? sa + sb : sa - sb;
          v = (s > 32767) || (s < -32768);
`ifdef CVP14_SAT_ARITH_EN
          r[rd] = (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : s[15:0];
`else
          r[rd] = s[15:0];
`endif
        end
        OP_AND:  r[rd] = a & b;
        OP_XOR:  r[rd] = a ^ b;
        OP_SLL:  r[rd][7:0]  = ir[7:0];
        OP_SLH:  r[rd][15:8] = ir[7:0];
        OP_LD: begin
          r[rd] = ref_mem[ea];
          cyc += 1;
        end
        OP_ST: begin
          ref_mem[ea] = r[rd];
          exp_q.push_back({ea, r[rd]});
        end
        OP_J:    pc = {pc[15:12], ir[11:0]};
        OP_BEQZ: if (r[rd] == 16'h0) pc = 16'(int'(pc) + int'($signed(ir[8:0])));
        OP_HALT: begin
          cyc += 3; vout = v; ok = 1'b1;
          return;
        end
        default: ;
      endcase
      cyc += 3;
    end
  endtask

  task automatic run_prog(input string nm);
    int   exp_cyc, zeros, cyc, hit;
    logic exp_v;
    bit   ok, done, bad;
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
    exp_q.delete();
    ref_run(exp_cyc, exp_v, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    Reset = 1'b1;
    @(posedge Clk1); @(posedge Clk1); #1;
    chk({nm, "_rst_strobes"}, {30'd0, RD, WR}, 32'd0);
    @(negedge Clk1);
    Reset = 1'b0;
    zeros = 0; done = 1'b0; hit = -1;
    for (cyc = 0; cyc < exp_cyc + 20 && !done; cyc++) begin
      #1;
      if (cyc < 64) begin tr_addr[cyc] = Addr; tr_rd[cyc] = RD; end
      if (!RD && !WR) zeros++; else zeros = 0;
      if (zeros == 3) begin done = 1'b1; hit = cyc; end
      else @(negedge Clk1);
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no HALT after %0d cycles, expected HALT at cycle %0d", nm, cyc, exp_cyc);
    end else begin
      chk({nm, "_cycles"}, hit, exp_cyc);
    end
    chk({nm, "_V"}, {31'd0, V}, {31'd0, exp_v});
    chk({nm, "_pending_writes"}, exp_q.size(), 0);
    bad = 1'b0;
    repeat (4) begin @(negedge Clk1); #1; if (RD || WR) bad = 1'b1; end
    chk({nm, "_halt_idle"}, {31'd0, bad}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    // Byte assembly and store
    mem[0] = iI8(OP_SLL, 1, 8'h34); mem[1] = iI8(OP_SLH, 1, 8'h12);
    mem[2] = iM(OP_ST, 1, 0, 6'h10); mem[3] = HALT_W;
    run_prog("bytes");
    chk("bytes_mem", {16'h0, mem[16'h0010]}, 32'h1234);

    // Signed overflow on ADD, then cleared by SUB
    mem[0] = iI8(OP_SLL, 1, 8'hFF); mem[1] = iI8(OP_SLH, 1, 8'h7F);
    mem[2] = iI8(OP_SLL, 2, 8'h01); mem[3] = iR(OP_ADD, 3, 1, 2);
    mem[4] = iM(OP_ST, 3, 0, 6'h11); mem[5] = HALT_W;
    run_prog("add_ovf");
    mem[5] = iR(OP_SUB, 4, 3, 3); mem[6] = iM(OP_ST, 4, 0, 6'h12); mem[7] = HALT_W;
    run_prog("sub_clr");

    // Load latency and address
    mem[16'h0020] = 16'hBEEF;
    mem[0] = iM(OP_LD, 5, 0, 6'h20); mem[1] = iM(OP_ST, 5, 0, 6'h21); mem[2] = HALT_W;
    run_prog("ld");
    chk("ld_exec_addr", {16'h0, tr_addr[2]}, 32'h0020);
    chk("ld_exec_rd", {31'd0, tr_rd[2]}, 32'd1);
    chk("ld_ldwb_rd", {31'd0, tr_rd[3]}, 32'd0);
    chk("ld_next_fetch", {15'd0, tr_rd[4], tr_addr[4]}, {15'd0, 1'b1, 16'h0001});

    // Countdown loop
    mem[0] = iI8(OP_SLL, 1, 8'h03); mem[1] = iI8(OP_SLL, 2, 8'h01);
    mem[2] = iR(OP_SUB, 1, 1, 2); mem[3] = {OP_BEQZ, 3'd1, 9'd1};
    mem[4] = {OP_J, 12'h002}; mem[5] = iM(OP_ST, 1, 0, 6'h30); mem[6] = HALT_W;
    run_prog("loop");
    chk("loop_cycles_total", 36, 36 + 0 * int'(mem[16'h0030] !== 16'h0));
    chk("loop_mem", {16'h0, mem[16'h0030]}, 32'h0000);

    // Unused opcode as NOP, J with imm12 = FFF
    mem[0] = 16'hC000;
    for (int i = 1; i < 5; i++) mem[i] = 16'h0000;
    mem[5] = {OP_J, 12'hFFF}; mem[16'h0FFF] = HALT_W;
    run_prog("jump");
    chk("jump_fetch", {15'd0, tr_rd[18], tr_addr[18]}, {15'd0, 1'b1, 16'h0FFF});

    // Reset during LDWB
    mem[0] = iI8(OP_SLH, 1, 8'h80); mem[1] = iR(OP_ADD, 2, 1, 1);
    mem[2] = iM(OP_LD, 5, 0, 6'h20); mem[3] = HALT_W;
    exp_q.delete();
    Reset = 1'b1;
    @(posedge Clk1); @(posedge Clk1);
    @(negedge Clk1); Reset = 1'b0;
    repeat (8) @(negedge Clk1);
    #1;
    chk("rstld_v_before", {31'd0, V}, 32'd1);
    chk("rstld_exec", {15'd0, RD, Addr}, {15'd0, 1'b1, 16'h0020});
    @(negedge Clk1);
    Reset = 1'b1;
    #1;
    chk("rstld_strobes", {30'd0, RD, WR}, 32'd0);
    mem[0] = iM(OP_ST, 5, 0, 6'h22); mem[1] = HALT_W;
    exp_q.push_back({16'h0022, 16'h0000});
    @(negedge Clk1);
    Reset = 1'b0;
    #1;
    chk("rstld_after", {14'd0, V, RD, Addr}, {14'd0, 1'b0, 1'b1, 16'h0000});
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clk1);
    chk("rstld_pending_writes", exp_q.size(), 0);

    // Randomized straight-line programs with a register dump
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 24; i++) begin
        case ($urandom_range(0, 9))
          0: op = OP_ADD;  1: op = OP_SUB;  2: op = OP_AND;  3: op = OP_XOR;
          4: op = OP_SLL;  5: op = OP_SLH;  6: op = OP_LD;   7: op = OP_ST;
          8: op = OP_NOP;  default: op = 4'(11 + $urandom_range(0, 3));
        endcase
        mem[i] = {op, 12'($urandom)};
      end
      for (int k = 0; k < 8; k++) mem[24 + k] = iM(OP_ST, k, 0, 6'(32 + k));
      mem[32] = HALT_W;
      run_prog("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
